// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus initiator (load/store unit).
// RV32I funct3 size/sign codes, FSM state encoding and funct3 legality helpers.
package dbus_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/dbus_lane_steer.sv
// Combinational byte-lane steering: store byte enables/replicated data,
// load lane extraction with sign/zero extension, and alignment check.
module dbus_lane_steer
    import dbus_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] data_in,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_raw[{addr, 3'b000} +: 8];
    assign half_lane = rdata_raw[{addr[1], 4'b0000} +: 16];

    // funct3[1:0] encodes access size for both loads and stores
    always_comb begin
        byte_en    = 4'b0000;
        data_in    = 32'h0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr;
                data_in = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << {addr[1], 1'b0};
                data_in    = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            2'b10: begin
                byte_en    = 4'b1111;
                data_in    = wdata;
                misaligned = |addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   rdata_ext = {24'h0, byte_lane};
            F3_H:    rdata_ext = {{16{half_lane[15]}}, half_lane};
            F3_HU:   rdata_ext = {16'h0, half_lane};
            F3_W:    rdata_ext = rdata_raw;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dbus_initiator.sv
// DarkRISCV load/store unit: accepts one request at a time, drives the Memory
// data port, waits out halt (with timeout) and returns extended load data.
module dbus_initiator
    import dbus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] data_in,
    output logic            write,
    output logic            read,
    output logic [3:0]      byte_en,
    input  logic [XLEN-1:0] data_out,
    input  logic            halt,
    output state_t          dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: a request transfers on a rising clk edge when req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and exactly one
    // response (resp_valid pulse) follows each accepted load/store request.

    state_t          state;
    logic [1:0]      addr_lo_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [CW-1:0]   wait_cnt;

    logic [2:0]      st_funct3;
    logic [1:0]      st_addr;
    logic [3:0]      st_byte_en;
    logic [XLEN-1:0] st_data_in;
    logic [XLEN-1:0] st_rdata_ext;
    logic            st_misaligned;
    logic            legal;

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    // In IDLE the steering decodes the incoming request; afterwards the latched one
    assign st_funct3 = (state == IDLE) ? req_funct3    : f3_q;
    assign st_addr   = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

    dbus_lane_steer u_steer (
        .funct3     (st_funct3),
        .addr       (st_addr),
        .wdata      (req_wdata),
        .rdata_raw  (data_out),
        .byte_en    (st_byte_en),
        .data_in    (st_data_in),
        .rdata_ext  (st_rdata_ext),
        .misaligned (st_misaligned)
    );

    assign legal = (req_load ^ req_store) && !st_misaligned &&
                   (req_load ? load_f3_ok(req_funct3) : store_f3_ok(req_funct3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_lo_q  <= 2'b00;
            f3_q       <= 3'b000;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byte_en    <= 4'b0000;
            data_addr  <= '0;
            data_in    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && (req_load || req_store)) begin
                        addr_lo_q <= req_addr[1:0];
                        f3_q      <= req_funct3;
                        rdata_q   <= '0;
                        if (!legal) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else if (req_load) begin
                            err_q     <= 1'b0;
                            read      <= 1'b1;
                            data_addr <= req_addr;
                            wait_cnt  <= '0;
                            state     <= LOAD;
                        end else begin
                            err_q     <= 1'b0;
                            write     <= 1'b1;
                            data_addr <= req_addr;
                            byte_en   <= st_byte_en;
                            data_in   <= st_data_in;
                            state     <= STORE;
                        end
                    end
                end
                LOAD: begin
                    if (!halt) begin
                        rdata_q <= st_rdata_ext;
                        read    <= 1'b0;
                        state   <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        read  <= 1'b0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                STORE: begin
                    write   <= 1'b0;
                    byte_en <= 4'b0000;
                    data_in <= '0;
                    state   <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= err_q ? '0 : rdata_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: directed load/store vectors against a small Memory
// model, with a response scoreboard checked by an independent monitor.
module tb_dbus_initiator;
    import dbus_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        write;
    logic        read;
    logic [3:0]  byte_en;
    logic [31:0] data_out;
    logic        halt;
    state_t      dbg_state;

    logic        force_halt;
    logic        rd_ack;
    logic [31:0] mem [0:255];

    logic [32:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    dbus_initiator #(.TIMEOUT(16), .XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .write      (write),
        .read       (read),
        .byte_en    (byte_en),
        .data_out   (data_out),
        .halt       (halt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Memory model: read acked one cycle after read ----------------
    assign halt = force_halt | (read & ~rd_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_ack <= 1'b0;
        else       rd_ack <= read & ~rd_ack;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        data_out <= mem[data_addr[9:2]];
        if (write && !data_addr[31]) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[data_addr[9:2]][b*8 +: 8] <= data_in[b*8 +: 8];
        end
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e[31:0]);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
                end
            end
            if (!write) check("idle_bus_be_din", {28'h0, byte_en} | data_in, 32'h0);
            check("rd_wr_exclusive", {31'h0, read & write}, 32'h0);
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_rd, input int exp_wr,
                         input logic [3:0] exp_be, input logic [31:0] exp_din,
                         input string tag);
        int k;
        int rd_cnt;
        int wr_cnt;
        logic [3:0]  seen_be;
        logic [31:0] seen_din;
        k = 0;
        while (!req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check({tag, "_ready_wait"}, 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
        k = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        seen_be  = 4'h0;
        seen_din = 32'h0;
        @(negedge clk);
        while (!resp_valid && k < 40) begin
            if (read) rd_cnt++;
            if (write) begin
                wr_cnt++;
                seen_be  = byte_en;
                seen_din = data_in;
            end
            @(negedge clk);
            k++;
        end
        if (!resp_valid) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_read_cycles"}, rd_cnt, exp_rd);
        check({tag, "_write_cycles"}, wr_cnt, exp_wr);
        if (exp_wr != 0) begin
            check({tag, "_byte_en"}, {28'h0, seen_be}, {28'h0, exp_be});
            check({tag, "_data_in"}, seen_din, exp_din);
        end
        check({tag, "_ready_at_resp"}, {31'h0, req_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        force_halt = 1'b0;
        req_valid = 1'b0;
        req_load = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", {31'h0, read}, 32'd0);
        check("rst_write", {31'h0, write}, 32'd0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'h0, resp_err}, 32'd0);
        check("rst_byte_en", {28'h0, byte_en}, 32'd0);
        check("rst_data_addr", data_addr, 32'd0);
        check("rst_data_in", data_in, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // word store / load
        issue(0, 1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 4'b1111, 32'hDEADBEEF, "sw");
        issue(1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 2, 0, 4'h0, 32'h0, "lw");
        // byte lane 3: word becomes 80ADBEEF
        issue(0, 1, F3_B, 32'h103, 32'h00000080, 32'h0, 0, 2, 0, 1, 4'b1000, 32'h80808080, "sb3");
        issue(1, 0, F3_B, 32'h103, 32'h0, 32'hFFFFFF80, 0, 3, 2, 0, 4'h0, 32'h0, "lb3");
        issue(1, 0, F3_BU, 32'h103, 32'h0, 32'h00000080, 0, 3, 2, 0, 4'h0, 32'h0, "lbu3");
        // upper half: word becomes 8001BEEF
        issue(0, 1, F3_H, 32'h102, 32'h00008001, 32'h0, 0, 2, 0, 1, 4'b1100, 32'h80018001, "sh2");
        issue(1, 0, F3_H, 32'h102, 32'h0, 32'hFFFF8001, 0, 3, 2, 0, 4'h0, 32'h0, "lh2");
        issue(1, 0, F3_HU, 32'h102, 32'h0, 32'h00008001, 0, 3, 2, 0, 4'h0, 32'h0, "lhu2");
        issue(1, 0, F3_H, 32'h100, 32'h0, 32'hFFFFBEEF, 0, 3, 2, 0, 4'h0, 32'h0, "lh0");
        issue(1, 0, F3_B, 32'h100, 32'h0, 32'hFFFFFFEF, 0, 3, 2, 0, 4'h0, 32'h0, "lb0");
        issue(1, 0, F3_BU, 32'h101, 32'h0, 32'h000000BE, 0, 3, 2, 0, 4'h0, 32'h0, "lbu1");
        // byte lane 1 from low byte of wider wdata: word becomes 80017FEF
        issue(0, 1, F3_B, 32'h101, 32'h1234567F, 32'h0, 0, 2, 0, 1, 4'b0010, 32'h7F7F7F7F, "sb1");
        issue(1, 0, F3_B, 32'h101, 32'h0, 32'h0000007F, 0, 3, 2, 0, 4'h0, 32'h0, "lb1");
        // addr[31] store is issued but Memory drops it
        issue(0, 1, F3_W, 32'h80000100, 32'h11111111, 32'h0, 0, 2, 0, 1, 4'b1111, 32'h11111111, "sw_hi");
        issue(1, 0, F3_W, 32'h100, 32'h0, 32'h80017FEF, 0, 3, 2, 0, 4'h0, 32'h0, "lw_after_hi");

        // illegal requests: error after 1 cycle, no bus activity
        issue(1, 0, F3_W, 32'h101, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, "lw_misal");
        issue(0, 1, F3_H, 32'h103, 32'hFFFF, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, "sh_misal");
        issue(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, "ld_f3_011");
        issue(0, 1, F3_BU, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, "st_f3_100");
        issue(1, 1, F3_W, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 4'h0, 32'h0, "ld_and_st");

        // neither load nor store: ignored
        req_valid = 1'b1;
        req_funct3 = F3_W;
        req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("neither_ready", {31'h0, req_ready}, 32'd1);
        check("neither_read", {31'h0, read | write}, 32'd0);
        repeat (3) @(negedge clk);

        // permanent halt: timeout after 16 LOAD cycles
        force_halt = 1'b1;
        issue(1, 0, F3_W, 32'h100, 32'h0, 32'h0, 1, 17, 16, 0, 4'h0, 32'h0, "timeout");
        force_halt = 1'b0;
        issue(1, 0, F3_W, 32'h100, 32'h0, 32'h80017FEF, 0, 3, 2, 0, 4'h0, 32'h0, "lw_after_to");

        // async reset in the middle of a load
        @(negedge clk);
        force_halt = 1'b1;
        req_valid = 1'b1;
        req_load = 1'b1;
        req_funct3 = F3_W;
        req_addr = 32'h104;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_load = 1'b0;
        check("mid_load_read", {31'h0, read}, 32'd1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_read", {31'h0, read}, 32'd0);
        check("rst_mid_state", {30'h0, dbg_state}, {30'h0, IDLE});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        force_halt = 1'b0;
        begin
            logic saw;
            saw = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (resp_valid) saw = 1'b1;
            end
            check("rst_no_resp", {31'h0, saw}, 32'd0);
        end
        check("rst_ready_after", {31'h0, req_ready}, 32'd1);
        issue(1, 0, F3_H, 32'h102, 32'h0, 32'hFFFF8001, 0, 3, 2, 0, 4'h0, 32'h0, "lh_after_rst");

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dbus_initiator.md
Name: dbus_initiator

Overview:
- Data-bus initiator (load/store unit) for the DarkRISCV core.
- Takes one load or store request at a time from the execute stage and drives the `Memory` data port: `data_addr`, `data_in`, `write`, `read`, `byte_en`.
- Honours the memory's `halt` stall, then returns aligned, sign/zero-extended load data to writeback.
- Sits between the core pipeline and `Memory`; instruction fetch is out of scope.

Parameters:
- TIMEOUT, 16, cycles a load may wait with `halt` high before it is aborted with an error.
- XLEN, 32, data and address width; fixed at 32.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  initiator can accept a request this cycle
- req_load  in  1  request is a load
- req_store  in  1  request is a store; load and store both high is illegal and maps to error
- req_funct3  in  3  RV32I size/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse; response fields valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access, bad funct3, or timeout
- data_addr  out  32  to `Memory`
- data_in  out  32  to `Memory`
- write  out  1  to `Memory`
- read  out  1  to `Memory`
- byte_en  out  4  to `Memory`
- data_out  in  32  from `Memory`; registered, reflects the previous cycle's `data_addr`
- halt  in  1  from `Memory`; high while a read awaits its ack

Behaviour:
- Clock is `clk`. Reset is asynchronous and active-high on `reset`.
- All outputs are registered except `req_ready`, which is `(state==IDLE)`.
- Reset values: state=IDLE; `read`, `write`, `resp_valid`, `resp_err` = 0; `byte_en`=0; `data_addr`, `data_in`, `resp_rdata` = 0.
- Reset asserted mid-operation drops `read`/`write` immediately and discards the request; no response is issued.
- States: IDLE, LOAD, STORE, RESP.
- IDLE, request accepted (`req_valid`, i.e. `req_valid & req_ready`):
  - Latch `addr`, `funct3`, `wdata`.
  - Legality check:
    - LH/LHU/SH need `addr[0]==0`.
    - LW/SW need `addr[1:0]==0`.
    - Load funct3 must be one of 000, 001, 010, 100, 101.
    - Store funct3 must be one of 000, 001, 010.
    - Exactly one of `req_load`/`req_store` must be high.
  - Illegal: go to RESP with err=1; no bus activity.
  - Legal load: go to LOAD.
  - Legal store: go to STORE.
  - `req_valid` with neither load nor store: ignored.
- LOAD:
  - Drives `read`=1 and `data_addr`=addr, with the wait counter cleared on entry.
  - Each cycle with `halt`=1, increment the counter. When it reaches TIMEOUT-1: drop `read`, go to RESP with err=1.
  - First cycle with `halt`=0: capture `data_out` through the extractor, drop `read`, go to RESP.
  - Against `Memory` (ack one cycle after `read`), the load takes 2 cycles in LOAD.
- STORE:
  - Exactly one cycle with `write`=1, `data_addr`=addr, `byte_en` and `data_in` steered; then go to RESP.
  - Stores ignore `halt` (memory never halts writes).
  - Addresses with `addr[31]=1` are still issued; `Memory` drops them.
- RESP: `resp_valid`=1 for one cycle, then IDLE. `req_ready` rises the cycle after RESP.
- Latency from acceptance edge to `resp_valid`:
  - load: 3 cycles
  - store: 2 cycles
  - error: 1 cycle
- Byte enables:
  - SB: `4'b0001 << addr[1:0]`
  - SH: `4'b0011 << {addr[1],1'b0}`
  - SW: `4'b1111`
- Store data:
  - SB: `{4{wdata[7:0]}}`
  - SH: `{2{wdata[15:0]}}`
  - SW: `wdata`
- Load extract:
  - byte lane `data_out[addr[1:0]*8 +: 8]`
  - half lane `data_out[addr[1]*16 +: 16]`
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `byte_en`/`data_in` are 0 whenever `write`=0.

Decomposition:
- Package `dbus_pkg`:
  - funct3 constants: `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101.
  - `state_t` enum: IDLE, LOAD, STORE, RESP.
  - `TIMEOUT` default.
- Sub-module `dbus_lane_steer` (combinational):
  - inputs: `funct3`, `addr[1:0]`, `wdata`, `rdata_raw`
  - outputs: `byte_en`, `data_in`, `rdata_ext`, `misaligned`
- Top holds the FSM, request latches and timeout counter.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, then LW 0x100 → `write` pulse with `byte_en`=1111; load `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` 3 cycles after acceptance, `read` high exactly 2 cycles.
- SB 0x80 at addr 0x103, then LB 0x103 / LBU 0x103 → `byte_en`=1000, `data_in`=0x80808080; LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH 0x8001 at addr 0x102, then LH/LHU 0x102 → `byte_en`=1100; LH=0xFFFF8001; LHU=0x00008001.
- LW addr=0x101, SH addr=0x103, funct3=011 load → each gives `resp_valid`+`resp_err` 1 cycle after acceptance; `read`/`write` never asserted.
- Force `halt`=1 permanently during a load, TIMEOUT=16 → `read` drops and `resp_err`=1 after 16 LOAD cycles; next request is accepted.
- Assert `reset` while in LOAD → `read`=0 within the same cycle (async), `resp_valid` never pulses, `req_ready`=1 after reset release.
